// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch with BTB-steered PC and
//               a circular fetch queue feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h6000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] btb_pc,
    input  logic [31:0] btb_next_pc,
    input  logic        btb_taken,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        deq_valid,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_instr,
    output logic [31:0] deq_pred_next_pc,
    output logic        deq_pred_taken
);

    localparam int c_PTR_W = $clog2(FQ_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 97;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FQ_DEPTH);

    localparam logic [1:0] c_ISSUE = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_DROP  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [31:0]         r_pc;
    logic [31:0]         r_pend_pc;
    logic [31:0]         r_pend_next;
    logic                r_pend_taken;
    logic [c_ENT_W-1:0]  r_q_mem [FQ_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_issue;
    logic                w_enq;
    logic                w_deq;
    logic [c_ENT_W-1:0]  w_head;

    assign btb_pc    = r_pc;
    assign imem_addr = r_pc;

    // Only the WAIT state accepts a response; anything seen in ISSUE/DROP is dropped.
    assign w_enq = !rst && (r_state == c_WAIT) && imem_resp && !redirect_valid;
    assign w_deq = deq_valid && deq_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        imem_rmask  = 4'h0;
        case (r_state)
            c_ISSUE: begin
                if (!rst && !redirect_valid && (r_count < c_DEPTH)) begin
                    w_issue     = 1'b1;
                    imem_rmask  = 4'hF;
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_resp ? c_ISSUE : c_DROP;
                end else if (imem_resp) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_DROP: begin
                if (imem_resp) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            default: w_state_nxt = c_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_enq) begin
            r_pc <= r_pend_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_pc    <= 32'h0;
            r_pend_next  <= 32'h0;
            r_pend_taken <= 1'b0;
        end else if (w_issue) begin
            r_pend_pc    <= r_pc;
            r_pend_next  <= btb_next_pc;
            r_pend_taken <= btb_taken;
        end
    end

    // Redirect flushes the queue and wins over any same-cycle enqueue/dequeue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_mem[r_wr_ptr] <= {r_pend_pc, imem_rdata, r_pend_next, r_pend_taken};
        end
    end

    assign w_head           = r_q_mem[r_rd_ptr];
    assign deq_valid        = (r_count != '0);
    assign deq_pc           = w_head[96:65];
    assign deq_instr        = w_head[64:33];
    assign deq_pred_next_pc = w_head[32:1];
    assign deq_pred_taken   = w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized fetch_unit bench against a queue-based fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_RST_PC = 32'h6000_0000;
    localparam int          c_DEPTH  = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] nxt;
        logic        tk;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] btb_pc;
    logic [31:0] btb_next_pc;
    logic        btb_taken;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [31:0] deq_pred_next_pc;
    logic        deq_pred_taken;
    logic        btb_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Toy BTB: predicts taken on one slot in eight.
    assign btb_taken   = btb_en && (btb_pc[4:2] == 3'd1);
    assign btb_next_pc = btb_taken ? (btb_pc + 32'h0000_00F8) : (btb_pc + 32'd4);

    fetch_unit #(.RESET_PC(c_RST_PC), .FQ_DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .btb_pc(btb_pc), .btb_next_pc(btb_next_pc), .btb_taken(btb_taken),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc),
        .deq_instr(deq_instr), .deq_pred_next_pc(deq_pred_next_pc),
        .deq_pred_taken(deq_pred_taken)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fetch PC, one optional in-flight request, a discard flag.
    logic [31:0] m_pc;
    logic        m_out, m_drop;
    logic [31:0] m_pend_pc, m_pend_next;
    logic        m_pend_tk;
    ent_t        m_q[$];

    logic        mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;

    initial begin
        int rst_left;
        int rdy_pct;
        logic [3:0] exp_rm;
        logic pop;
        ent_t e;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        imem_resp = 1'b0; imem_rdata = '0; btb_en = 1'b0;
        m_pc = c_RST_PC; m_out = 1'b0; m_drop = 1'b0;
        m_pend_pc = '0; m_pend_next = '0; m_pend_tk = 1'b0;
        mem_busy = 1'b0; mem_wait = 0; mem_addr = '0;
        rst_left = 0;
        repeat (2) @(posedge clk);

        for (int ph = 0; ph < 4; ph++) begin
            rdy_pct = (ph == 0) ? 95 : (ph == 1) ? 50 : (ph == 2) ? 10 : 100;
            btb_en  = (ph != 2);
            for (int cyc = 0; cyc < 1000; cyc++) begin
                @(negedge clk);
                if (rst_left > 0) begin
                    rst_left--;
                end else if ($urandom_range(0, 149) == 0) begin
                    rst_left = $urandom_range(0, 2);
                end
                rst = (cyc < 2 && ph == 0) || (rst_left > 0) || ($urandom_range(0, 149) == 0);
                redirect_valid = ($urandom_range(0, 99) < 4);
                redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8
                                                         : {16'h6000, 14'($urandom), 2'b00};
                deq_ready = ($urandom_range(0, 99) < rdy_pct);
                if (mem_busy && mem_wait == 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = mem_addr ^ 32'hDEAD_BEEF;
                    mem_busy   = 1'b0;
                end else begin
                    if (mem_busy) mem_wait--;
                    imem_rdata = $urandom;
                    imem_resp  = !mem_busy && !m_out && !m_drop && ($urandom_range(0, 19) == 0);
                end
                #1;

                exp_rm = (!rst && !m_out && !m_drop && !redirect_valid && m_q.size() < c_DEPTH)
                         ? 4'hF : 4'h0;
                check("btb_pc", btb_pc, m_pc);
                check("imem_rmask", {28'h0, imem_rmask}, {28'h0, exp_rm});
                if (exp_rm == 4'hF) check("imem_addr", imem_addr, m_pc);
                check("deq_valid", {31'h0, deq_valid}, {31'h0, m_q.size() != 0});
                if (m_q.size() != 0) begin
                    check("deq_pc", deq_pc, m_q[0].pc);
                    check("deq_instr", deq_instr, m_q[0].instr);
                    check("deq_pred_next_pc", deq_pred_next_pc, m_q[0].nxt);
                    check("deq_pred_taken", {31'h0, deq_pred_taken}, {31'h0, m_q[0].tk});
                end

                if (rst) begin
                    m_pc = c_RST_PC; m_q.delete(); m_out = 1'b0; m_drop = 1'b0;
                    mem_busy = 1'b0;
                end else begin
                    if (imem_rmask == 4'hF && !mem_busy) begin
                        mem_busy = 1'b1;
                        mem_addr = imem_addr;
                        mem_wait = $urandom_range(0, 2);
                    end
                    pop = (m_q.size() != 0) && deq_ready;
                    if (redirect_valid) m_q.delete();
                    else if (pop) void'(m_q.pop_front());
                    if (m_out) begin
                        if (imem_resp) begin
                            m_out = 1'b0;
                            if (!redirect_valid) begin
                                e.pc = m_pend_pc; e.instr = imem_rdata;
                                e.nxt = m_pend_next; e.tk = m_pend_tk;
                                m_q.push_back(e);
                                m_pc = m_pend_next;
                            end
                        end else if (redirect_valid) begin
                            m_out = 1'b0; m_drop = 1'b1;
                        end
                    end else if (m_drop) begin
                        if (imem_resp) m_drop = 1'b0;
                    end else if (exp_rm == 4'hF) begin
                        m_out = 1'b1; m_pend_pc = m_pc;
                        m_pend_tk = btb_taken; m_pend_next = btb_next_pc;
                    end
                    if (redirect_valid) m_pc = redirect_pc;
                end
                @(posedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
